// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: instruction field
// positions, opcode values and FSM state encodings.
package pipe_pkg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  // Instruction field bit positions
  localparam int unsigned OP_HI = 31;
  localparam int unsigned OP_LO = 27;
  localparam int unsigned RD_HI = 26;
  localparam int unsigned RD_LO = 22;
  localparam int unsigned RS_HI = 21;
  localparam int unsigned RS_LO = 17;
  localparam int unsigned RT_HI = 16;
  localparam int unsigned RT_LO = 12;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [OP_W-1:0] OP_BNE   = 5'b00010;
  localparam logic [OP_W-1:0] OP_JR    = 5'b00100;
  localparam logic [OP_W-1:0] OP_BLT   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SW    = 5'b00111;
  localparam logic [OP_W-1:0] OP_LW    = 5'b01000;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the D/X instruction is a load whose destination is read by the
// F/D instruction. rs is always a source; rt is a source for R-type; rd is a
// source for sw, bne, blt and jr. A load into r0 never creates a hazard.
// Ports: fd_ins (F/D instruction), dx_ins (D/X instruction), hazard (out).
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [INS_W-1:0] fd_ins,
  input  logic [INS_W-1:0] dx_ins,
  output logic             hazard
);

  logic [OP_W-1:0]  fd_op;
  logic [REG_W-1:0] fd_rd;
  logic [REG_W-1:0] fd_rs;
  logic [REG_W-1:0] fd_rt;
  logic [OP_W-1:0]  dx_op;
  logic [REG_W-1:0] dx_rd;
  logic             fd_reads_rd;
  logic             fd_reads_rt;
  logic             unused_bits;

  assign fd_op = fd_ins[OP_HI:OP_LO];
  assign fd_rd = fd_ins[RD_HI:RD_LO];
  assign fd_rs = fd_ins[RS_HI:RS_LO];
  assign fd_rt = fd_ins[RT_HI:RT_LO];
  assign dx_op = dx_ins[OP_HI:OP_LO];
  assign dx_rd = dx_ins[RD_HI:RD_LO];

  // Immediate/low bits play no part in hazard detection
  assign unused_bits = ^{fd_ins[RT_LO-1:0], dx_ins[RS_HI:0]};

  // Source-operand usage of the F/D instruction, then the match
  always_comb begin
    fd_reads_rt = (fd_op == OP_RTYPE);
    fd_reads_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                  (fd_op == OP_BLT) || (fd_op == OP_JR);
    hazard      = (dx_op == OP_LW) && (dx_rd != '0) &&
                  ((dx_rd == fd_rs) ||
                   (fd_reads_rt && (dx_rd == fd_rt)) ||
                   (fd_reads_rd && (dx_rd == fd_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives PC/latch enables and flushes for taken
// branches, load-use bubbles and (optionally) multi-cycle mult/div stalls, and
// counts stalled cycles (saturating).
// Macro MULTDIV_STALL_EN: when defined, md_start/md_ready stall the pipe via
// the MD_WAIT state; when undefined they are ignored and state stays RUN.
// Ports: clk, reset_n (sync, active-low), fd_ins, dx_ins, branch_taken,
//   md_start, md_ready in; pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush,
//   stall_cnt[15:0], state[1:0] out. Enables/flushes are combinational.
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [INS_W-1:0] fd_ins,
  input  logic [INS_W-1:0] dx_ins,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             md_stall;
  logic             md_go;

  load_use_detect u_load_use_detect (
    .fd_ins (fd_ins),
    .dx_ins (dx_ins),
    .hazard (load_use)
  );

`ifdef MULTDIV_STALL_EN
  assign md_go    = md_start;
  assign md_stall = ~md_ready;
`else
  logic unused_md;
  assign unused_md = md_start ^ md_ready;
  assign md_go     = 1'b0;
  assign md_stall  = 1'b0;
`endif

  // State register and stall counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and enable/flush decode; branch > mult/div > load-use
  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    dx_en    = 1'b1;
    xm_en    = 1'b1;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (md_go) begin
            if (md_stall) begin
              pc_en   = 1'b0;
              fd_en   = 1'b0;
              dx_en   = 1'b0;
              xm_en   = 1'b0;
              state_d = ST_MD_WAIT;
            end
          end else if (load_use) begin
            // One bubble: hold PC and F/D, inject a nop into D/X
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          if (md_stall) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_en = 1'b0;
            xm_en = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles with the PC held
  always_comb begin
    cnt_d = cnt_q;
    if (!pc_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized stimulus
// compared cycle by cycle against a behavioural reference model.
module tb_pipe_hazard_ctrl;

`ifdef MULTDIV_STALL_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  localparam logic [4:0] LW = 5'b01000, RT = 5'b00000, SW = 5'b00111;
  localparam logic [4:0] BNE = 5'b00010, BLT = 5'b00110, JR = 5'b00100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fd_ins, dx_ins;
  logic        branch_taken, md_start, md_ready;
  logic        pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush;
  logic [15:0] stall_cnt;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;
  bit m_wait = 1'b0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fd_ins       (fd_ins),
    .dx_ins       (dx_ins),
    .branch_taken (branch_taken),
    .md_start     (md_start),
    .md_ready     (md_ready),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .dx_en        (dx_en),
    .xm_en        (xm_en),
    .fd_flush     (fd_flush),
    .dx_flush     (dx_flush),
    .stall_cnt    (stall_cnt),
    .state        (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  // Does the F/D instruction read the register a D/X load writes?
  function automatic bit ref_hazard(input logic [31:0] fi, input logic [31:0] di);
    int dop, drd, fop, frd, frs, frt;
    bit reads_rd;
    dop = int'(di[31:27]);
    drd = int'(di[26:22]);
    fop = int'(fi[31:27]);
    frd = int'(fi[26:22]);
    frs = int'(fi[21:17]);
    frt = int'(fi[16:12]);
    if (dop != 8 || drd == 0) return 1'b0;
    reads_rd = (fop == 7) || (fop == 2) || (fop == 6) || (fop == 4);
    return (drd == frs) || (fop == 0 && drd == frt) || (reads_rd && drd == frd);
  endfunction

  // One clock: drive, check outputs mid-cycle, advance the model at the edge
  task automatic step(input logic rn, input logic br, input logic ms, input logic mr,
                      input logic [31:0] fi, input logic [31:0] di, input bit chk);
    logic [5:0] e;   // {pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush}
    bit nxt_wait;
    reset_n = rn; branch_taken = br; md_start = ms; md_ready = mr;
    fd_ins = fi; dx_ins = di;
    e = 6'b111100;
    nxt_wait = 1'b0;
    if (rn) begin
      if (!m_wait) begin
        if (br) e = 6'b111111;
        else if (MD_ON && ms) begin
          e = mr ? 6'b111100 : 6'b000000;
          nxt_wait = !mr;
        end else if (ref_hazard(fi, di)) e = 6'b001101;
      end else begin
        e = mr ? 6'b111100 : 6'b000000;
        nxt_wait = !mr;
      end
    end
    @(negedge clk);
    if (chk) begin
      check_eq("pc_en", 32'(pc_en), 32'(e[5]));
      check_eq("fd_en", 32'(fd_en), 32'(e[4]));
      check_eq("dx_en", 32'(dx_en), 32'(e[3]));
      check_eq("xm_en", 32'(xm_en), 32'(e[2]));
      check_eq("fd_flush", 32'(fd_flush), 32'(e[1]));
      check_eq("dx_flush", 32'(dx_flush), 32'(e[0]));
      check_eq("state", 32'(state), 32'(m_wait));
      check_eq("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end
    @(posedge clk);
    if (!rn) begin
      m_wait = 1'b0;
      m_cnt  = 0;
    end else begin
      if (!e[5] && m_cnt < 65535) m_cnt++;
      m_wait = nxt_wait;
    end
    #1;
  endtask

  logic [31:0] nop;
  logic [4:0]  ops [6];

  initial begin
    nop = 32'h0;
    ops[0] = LW; ops[1] = RT; ops[2] = SW; ops[3] = BNE; ops[4] = BLT; ops[5] = JR;

    // Reset and the reset-held output values
    step(1'b0, 1'b0, 1'b0, 1'b0, nop, nop, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, mk(RT, 1, 3, 2), mk(LW, 3, 0, 0), 1'b1);
    check_eq("rst_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);

    // lw r3 followed by add reading r3: single bubble
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(RT, 1, 3, 2), mk(LW, 3, 0, 0), 1'b1);
    check_eq("lu_cnt", 32'(stall_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(RT, 1, 3, 2), mk(RT, 3, 0, 0), 1'b1);

    // lw r0 followed by add reading r0: no stall
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(RT, 1, 0, 0), mk(LW, 0, 0, 0), 1'b1);
    check_eq("r0_cnt", 32'(stall_cnt), 32'd1);

    // rt / rd source forms
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(RT, 1, 2, 5), mk(LW, 5, 0, 0), 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(SW, 6, 2, 0), mk(LW, 6, 0, 0), 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(LW, 6, 2, 6), mk(LW, 6, 0, 0), 1'b1);

    // Taken branch with concurrent load-use: flush, no stall
    step(1'b1, 1'b1, 1'b0, 1'b0, mk(RT, 1, 3, 2), mk(LW, 3, 0, 0), 1'b1);
    check_eq("br_cnt", 32'(stall_cnt), 32'd3);

    if (MD_ON) begin
      // Mult/div with result four cycles later
      step(1'b0, 1'b0, 1'b0, 1'b0, nop, nop, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, nop, nop, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, mk(RT, 1, 3, 2), mk(LW, 3, 0, 0), 1'b1);
      check_eq("md_cnt", 32'(stall_cnt), 32'd5);
      check_eq("md_state", 32'(state), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1, nop, nop, 1'b1);
      check_eq("md_back", 32'(state), 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b1, mk(RT, 1, 3, 2), mk(LW, 3, 0, 0), 1'b1);
      check_eq("md_rdy_cnt", 32'(stall_cnt), 32'd5);

      // Reset in the middle of MD_WAIT
      step(1'b1, 1'b0, 1'b1, 1'b0, nop, nop, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, nop, nop, 1'b1);
      check_eq("mdr_state", 32'(state), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, nop, nop, 1'b1);
      check_eq("mdr_state0", 32'(state), 32'd0);
      check_eq("mdr_cnt0", 32'(stall_cnt), 32'd0);
    end

    // Randomized traffic with small register numbers for frequent hazards
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] fi, di;
      fi = mk(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))) | 32'($urandom_range(0, 4095));
      di = mk(($urandom_range(0, 2) == 0) ? ops[$urandom_range(0, 5)] : LW,
              5'($urandom_range(0, 3)), 5'($urandom), 5'($urandom)) | 32'($urandom_range(0, 4095));
      step($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, fi, di, 1'b1);
    end

    // Long stall into saturation
    step(1'b0, 1'b0, 1'b0, 1'b0, nop, nop, 1'b1);
    for (int i = 0; i < 65534; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, mk(RT, 1, 3, 2), mk(LW, 3, 0, 0), 1'b0);
    check_eq("sat_pre", 32'(stall_cnt), 32'd65534);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, mk(RT, 1, 3, 2), mk(LW, 3, 0, 0), 1'b1);
    check_eq("sat_hold", 32'(stall_cnt), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have port: fd_ins  input  32  instruction held in F/D latch; opcode [31:27], rd [26:22], rs [21:17], rt [16:12].
REQ-004 SHALL have port: dx_ins  input  32  instruction held in D/X latch, same field layout.
REQ-005 SHALL have port: branch_taken  input  1  X-stage redirect (taken branch/jump) this cycle.
REQ-006 SHALL have port: md_start  input  1  X-stage mult/div issued this cycle.
REQ-007 SHALL have port: md_ready  input  1  mult/div result valid this cycle.
REQ-008 SHALL have ports: pc_en, fd_en, dx_en, xm_en  output  1 each  write enables for PC and the F/D, D/X, X/M latches.
REQ-009 SHALL have ports: fd_flush, dx_flush  output  1 each  load nop (32'h0) into the F/D / D/X latch on next edge.
REQ-010 SHALL have port: stall_cnt  output  16  count of cycles with pc_en=0.
REQ-011 SHALL have port: state  output  2  current FSM state (RUN=0, MD_WAIT=1).

Function
REQ-012 SHALL declare a load-use hazard when dx opcode=01000 (lw), dx rd != 0, and dx rd equals fd rs; or equals fd rt when fd opcode=00000; or equals fd rd when fd opcode is 00111, 00010, 00110 or 00100.
REQ-013 SHALL, in RUN with no event, drive all enables 1 and both flushes 0.
REQ-014 SHALL, in RUN on branch_taken, drive fd_flush=1 and dx_flush=1 with all enables 1, combinationally in the same cycle, and remain in RUN.
REQ-015 SHALL, in RUN on load-use hazard without branch_taken, drive pc_en=0, fd_en=0, dx_flush=1, xm_en=1 for exactly that cycle (one bubble).
REQ-016 SHALL, in RUN on md_start with md_ready=0 and branch_taken=0, drive pc_en=fd_en=dx_en=xm_en=0 in that cycle and enter MD_WAIT on next edge.
REQ-017 SHALL, in RUN with md_start and md_ready both 1, stay in RUN with all enables 1.
REQ-018 SHALL, in MD_WAIT with md_ready=0, hold pc_en=fd_en=dx_en=xm_en=0 and both flushes 0.
REQ-019 SHALL, in MD_WAIT with md_ready=1, drive all enables 1 that cycle and return to RUN on next edge.
REQ-020 SHALL prioritise branch_taken > md_start > load-use in RUN; lower-priority events that cycle are ignored.
REQ-021 SHALL ignore branch_taken, md_start and load-use while in MD_WAIT.
REQ-022 SHALL increment stall_cnt on each edge where pc_en=0 and saturate at 16'hFFFF without wrap.

Reset
REQ-023 SHALL, when reset_n=0 at an edge, set state=RUN and stall_cnt=0, including mid-MD_WAIT.
REQ-024 SHALL, while reset_n=0, drive all enables 1 and both flushes 0; stall_cnt SHALL NOT increment.

Configuration
REQ-025 SHALL support macro MULTDIV_STALL_EN: defined -> REQ-016 to REQ-019 as stated; undefined -> md_start/md_ready ignored, MD_WAIT unreachable, state held at 0.

Structure
REQ-026 SHALL place opcode constants (LW=01000, SW=00111, BNE=00010, BLT=00110, JR=00100, RTYPE=00000), field bit positions and state encodings in shared package pipe_pkg.
REQ-027 SHALL implement hazard comparison in sub-module load_use_detect (combinational, fd_ins/dx_ins in, hazard out); FSM and counter in the top.

Verification
REQ-028 SHALL cover: dx_ins=lw rd=3, fd_ins=add rs=3 -> one cycle pc_en=0, fd_en=0, dx_flush=1, stall_cnt 0->1.
REQ-029 SHALL cover: dx_ins=lw rd=0, fd_ins=add rs=0 -> no stall, all enables 1.
REQ-030 SHALL cover: md_start=1, md_ready after 4 cycles -> MD_WAIT for 4 cycles, enables 0, stall_cnt=5, then RUN.
REQ-031 SHALL cover: branch_taken=1 with concurrent load-use hazard -> fd_flush=dx_flush=1, pc_en=1, no stall.
REQ-032 SHALL cover: reset_n=0 during MD_WAIT -> state=RUN and stall_cnt=0 next edge; stall_cnt preset near 16'hFFFF then long stall -> holds 16'hFFFF.
